mem_bus_fabric: RTL
===================

Name: mem_bus_fabric

Overview:
- Parametrised memory-map fabric between the 6502 core bus and the system memories. Generalises the fixed RAM/ROM decode: configurable region sizes, a ready handshake with ROM wait states, and a small MMIO block driving the debug port and done flag.
- RAM and ROM macros sit outside this block. They connect through the ram_*/rom_* ports and are synchronous, with 1-cycle read latency.

Parameters:
- RAM_AW, 14: RAM address width. RAM occupies 0x0000 .. 2^RAM_AW-1.
- ROM_AW, 15: ROM address width. ROM occupies 0x10000-2^ROM_AW .. 0xFFFF.
- ROM_WAIT, 0: extra wait cycles for ROM reads (0..15).
- IO_BASE, 16'h4000: MMIO base address. Bits [1:0] are ignored; the block decodes 4 registers.
- UNMAPPED_DATA, 8'hFF: read data for unmapped addresses.
- DEV_ID, 8'h65: constant returned by the ID register.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, 1: bus request; addr, we and data_w are valid with it.
- we, input, 1: 1 = write, 0 = read.
- addr, input, 16: byte address.
- data_w, input, 8: write data.
- rdy, output, 1: one-cycle completion pulse.
- data_r, output, 8: read data, valid when rdy=1.
- ram_we, output, 1: RAM write strobe.
- ram_addr, output, RAM_AW: RAM address.
- ram_din, output, 8: RAM write data.
- ram_dout, input, 8: RAM read data, 1 cycle after the address.
- rom_addr, output, ROM_AW: ROM address.
- rom_dout, input, 8: ROM read data, 1 cycle after the address.
- dport_out, output, 8: debug port value.
- dport_write, output, 1: one-cycle pulse on each DPORT write.
- done, output, 1: sticky done flag.

Behaviour:
- Decode priority: IO > ROM > RAM > unmapped.
  - IO hit: addr[15:2]==IO_BASE[15:2].
  - ROM hit: addr >= 0x10000-2^ROM_AW.
  - RAM hit: addr < 2^RAM_AW.
- Memory ports are combinational from the inputs:
  - ram_addr = addr[RAM_AW-1:0]; rom_addr = addr[ROM_AW-1:0]; ram_din = data_w.
  - ram_we = req & we & RAM hit & state==IDLE.
- FSM states:
  - IDLE: on req, latch the region select and addr[1:0], apply any write, then go to:
    - WAIT with cnt=ROM_WAIT, if a ROM read and ROM_WAIT>0;
    - otherwise RESP.
  - WAIT: decrement cnt each cycle; when cnt==1, go to RESP.
  - RESP: rdy=1 for one cycle.
    - If req is high in the RESP cycle, it is accepted as a new IDLE-cycle request (back-to-back, no bubble).
    - Otherwise go to IDLE.
- Latency from req to rdy:
  - RAM, IO, unmapped, and all writes: 1 cycle.
  - ROM reads: 1+ROM_WAIT cycles.
- Requester behaviour: holds addr/we/data_w stable until rdy. req is ignored while in WAIT.
- data_r in the rdy cycle is muxed by the registered select: ram_dout, rom_dout, the IO register value, or UNMAPPED_DATA.
  - For ROM with wait states, rom_dout is taken in the RESP cycle; rom_addr is held by the requester.
  - data_r = 8'h00 when rdy=0.
- Writes to ROM or unmapped addresses: discarded, still acknowledged.
- MMIO registers (offset = addr[1:0]):
  - +0 DPORT: write loads dport_out and pulses dport_write in the same cycle as rdy. Read returns dport_out.
  - +1 DONE: any write sets done=1, which stays 1 until reset. Read returns {7'b0, done}.
  - +2 SCRATCH: 8-bit read/write register.
  - +3 ID: read returns DEV_ID; writes are ignored.
- Reset (async assert, any state including WAIT): state=IDLE, rdy=0, data_r=0, dport_out=0, dport_write=0, done=0, SCRATCH=0, cnt=0. Any in-flight transaction is dropped with no rdy.

Test Plan:
- RAM write 0x0123<=0xA5, then read 0x0123 -> ram_we high for exactly 1 cycle; read rdy 1 cycle after req; data_r=0xA5.
- ROM_WAIT=3, read 0xFFFC with rom_dout=0x80 -> rdy exactly 4 cycles after req; data_r=0x80; no rdy during WAIT.
- Write 0x4000<=0x41, then 0x4000<=0x42 -> dport_out=0x41 then 0x42; dport_write pulses once per write, coincident with rdy.
- Write 0x4001<=0x00 -> done=1 and stays 1 across later traffic. Read 0x4001 -> 0x01. Read 0x4003 -> 0x65.
- Back-to-back reads 0x0010, then 0x0011, with req held high -> rdy high two consecutive cycles, correct data each cycle. Read 0x6000 (unmapped) -> 0xFF; ram_we never asserted.
- Assert rst_n=0 mid-WAIT of a ROM read with done=1 -> all outputs 0 immediately, no rdy. After release, a RAM read completes normally.

Source files
------------

// File: rtl/mem_bus_fabric.sv
// Memory-map fabric between the 6502 core bus and external RAM/ROM macros.
// Decodes IO > ROM > RAM > unmapped, handshakes with rdy, and hosts 4 MMIO registers.
module mem_bus_fabric #(
  parameter int          RAM_AW        = 14,
  parameter int          ROM_AW        = 15,
  parameter int          ROM_WAIT      = 0,
  parameter logic [15:0] IO_BASE       = 16'h4000,
  parameter logic [7:0]  UNMAPPED_DATA = 8'hFF,
  parameter logic [7:0]  DEV_ID        = 8'h65
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [15:0]       addr,
  input  logic [7:0]        data_w,
  output logic              rdy,
  output logic [7:0]        data_r,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_dout,
  output logic [7:0]        dport_out,
  output logic              dport_write,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SEL_RAM, SEL_ROM, SEL_IO, SEL_NONE} sel_t;
  typedef struct packed {
    sel_t       sel;
    logic [1:0] off;
  } txn_t;

  localparam logic [16:0] ROM_BASE = 17'h10000 - (17'd1 << ROM_AW);
  localparam logic [16:0] RAM_TOP  = 17'd1 << RAM_AW;

  state_t     state;
  txn_t       txn;
  logic [3:0] cnt;
  logic [7:0] scratch;
  logic [7:0] io_rd;
  sel_t       dec_sel;
  logic       accept;

  always_comb begin
    if (addr[15:2] == IO_BASE[15:2])      dec_sel = SEL_IO;
    else if ({1'b0, addr} >= ROM_BASE)    dec_sel = SEL_ROM;
    else if ({1'b0, addr} < RAM_TOP)      dec_sel = SEL_RAM;
    else                                  dec_sel = SEL_NONE;
  end

  // RESP doubles as an accept cycle so back-to-back requests see no bubble.
  assign accept   = req && (state == IDLE || state == RESP);
  assign ram_addr = addr[RAM_AW-1:0];
  assign rom_addr = addr[ROM_AW-1:0];
  assign ram_din  = data_w;
  assign ram_we   = accept && we && (dec_sel == SEL_RAM);
  assign rdy      = (state == RESP);

  always_comb begin
    case (txn.off)
      2'd0:    io_rd = dport_out;
      2'd1:    io_rd = {7'b0, done};
      2'd2:    io_rd = scratch;
      default: io_rd = DEV_ID;
    endcase
  end

  always_comb begin
    data_r = 8'h00;
    if (rdy) begin
      case (txn.sel)
        SEL_RAM: data_r = ram_dout;
        SEL_ROM: data_r = rom_dout;
        SEL_IO:  data_r = io_rd;
        default: data_r = UNMAPPED_DATA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      txn         <= '{sel: SEL_NONE, off: 2'd0};
      cnt         <= 4'd0;
      dport_out   <= 8'h00;
      dport_write <= 1'b0;
      done        <= 1'b0;
      scratch     <= 8'h00;
    end else begin
      dport_write <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (req) begin
            txn <= '{sel: dec_sel, off: addr[1:0]};
            if (we && dec_sel == SEL_IO) begin
              case (addr[1:0])
                2'd0: begin
                  dport_out   <= data_w;
                  dport_write <= 1'b1;
                end
                2'd1:    done    <= 1'b1;
                2'd2:    scratch <= data_w;
                default: ;
              endcase
            end
            if (!we && dec_sel == SEL_ROM && ROM_WAIT > 0) begin
              state <= WAIT;
              cnt   <= 4'(ROM_WAIT);
            end else begin
              state <= RESP;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
